// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_pkg
// Description : Shared types and helpers for the PLL reset sequencer:
//               FSM state encoding, counter sizing and status widths.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_rst_pkg;

  // Width of the saturating watchdog retry counter
  localparam int RETRY_W = 8;

  // Sequencer states
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  // Counter width large enough for the longest terminal count of any phase
  function automatic int cnt_width(input int timeout_c, input int lock_c,
                                   input int pll_rst_c, input int release_c);
    int m;
    m = timeout_c;
    if (lock_c > m) m = lock_c;
    if (pll_rst_c > m) m = pll_rst_c;
    if (release_c > m) m = release_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser, asynchronous active-low reset to 0.
//               Also used for downstream per-domain reset synchronisers.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of an asynchronous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Holds an iCE40 PLL in reset, waits for and qualifies lock,
//               then releases N downstream resets in staggered order.
//               Watchdog retries the PLL; lock loss re-asserts all resets.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int N_DOMAINS      = 2,
  parameter int LOCK_CYCLES    = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  output logic                 pll_resetb,
  output logic [N_DOMAINS-1:0] dom_rst_n,
  output logic                 ready,
  output logic                 lock_lost,
  input  logic                 clear_lost,
  output logic [RETRY_W-1:0]   retry_count
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES, LOCK_CYCLES, PLL_RST_CYCLES,
                                (N_DOMAINS - 1) * STAGGER_CYCLES + 1);

  localparam logic [CW-1:0] c_pll_rst_last = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] c_timeout_last = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] c_lock_last    = CW'(LOCK_CYCLES - 1);

  // Parameter legality
  if (N_DOMAINS < 1) begin : g_chk_n_domains
    $error("pll_reset_sequencer: N_DOMAINS must be >= 1");
  end
  if (LOCK_CYCLES < 1) begin : g_chk_lock
    $error("pll_reset_sequencer: LOCK_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_chk_stagger
    $error("pll_reset_sequencer: STAGGER_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("pll_reset_sequencer: TIMEOUT_CYCLES must be >= 2");
  end
  if (PLL_RST_CYCLES < 1) begin : g_chk_pll_rst
    $error("pll_reset_sequencer: PLL_RST_CYCLES must be >= 1");
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pll_resetb_q, pll_resetb_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 ready_q, ready_d;
  logic                 lost_q, lost_d;
  logic                 lost_set;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 lock_s;
  logic [N_DOMAINS-1:0] rel_hit;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // Domain i is due for release when the RELEASE counter reaches i*STAGGER
  for (genvar i = 0; i < N_DOMAINS; i++) begin : g_rel_hit
    assign rel_hit[i] = (cnt_q == CW'(i * STAGGER_CYCLES));
  end

  // Next-state and registered-output logic for the sequencer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pll_resetb_d = pll_resetb_q;
    dom_d        = dom_q;
    ready_d      = ready_q;
    retry_d      = retry_q;
    lost_set     = 1'b0;

    case (state_q)
      PLL_RST: begin
        pll_resetb_d = 1'b0;
        if (cnt_q == c_pll_rst_last) begin
          state_d      = WAIT_LOCK;
          pll_resetb_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          // Lock wins over a coincident timeout
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == c_timeout_last) begin
          state_d      = PLL_RST;
          pll_resetb_d = 1'b0;
          cnt_d        = '0;
          if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STABLE: begin
        if (!lock_s) begin
          // Any dropout restarts qualification with a fresh watchdog window
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == c_lock_last) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          dom_d    = '0;
          ready_d  = 1'b0;
          lost_set = 1'b1;
        end else begin
          // OR-in only: a released domain never re-asserts here
          dom_d = dom_q | rel_hit;
          if (rel_hit[N_DOMAINS-1]) begin
            state_d = RUN;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      RUN: begin
        if (!lock_s) begin
          // PLL is left running; the watchdog retries it if lock stays away
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          dom_d    = '0;
          ready_d  = 1'b0;
          lost_set = 1'b1;
        end
      end

      default: begin
        state_d      = PLL_RST;
        cnt_d        = '0;
        pll_resetb_d = 1'b0;
        dom_d        = '0;
        ready_d      = 1'b0;
      end
    endcase
  end

  // Sticky lock-lost flag; a new loss outranks a clear in the same cycle
  always_comb begin
    lost_d = lost_q;
    if (lost_set) begin
      lost_d = 1'b1;
    end else if (clear_lost) begin
      lost_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      pll_resetb_q <= 1'b0;
      dom_q        <= '0;
      ready_q      <= 1'b0;
      lost_q       <= 1'b0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_resetb_q <= pll_resetb_d;
      dom_q        <= dom_d;
      ready_q      <= ready_d;
      lost_q       <= lost_d;
      retry_q      <= retry_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign dom_rst_n   = dom_q;
  assign ready       = ready_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed bench for pll_reset_sequencer. Expected output
//               changes (cycle + value) are queued by the stimulus and
//               popped by a monitor whenever the DUT outputs change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int N_DOM = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pll_locked = 1'b0;
  logic             clear_lost = 1'b0;
  logic             pll_resetb;
  logic [N_DOM-1:0] dom_rst_n;
  logic             ready;
  logic             lock_lost;
  logic [7:0]       retry_count;

  pll_reset_sequencer #(
    .N_DOMAINS      (N_DOM),
    .LOCK_CYCLES    (8),
    .STAGGER_CYCLES (4),
    .TIMEOUT_CYCLES (32),
    .PLL_RST_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_resetb  (pll_resetb),
    .dom_rst_n   (dom_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .clear_lost  (clear_lost),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge following reset release, cyc == k
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    int          cyc;
    logic [13:0] vec;
  } exp_t;

  exp_t exp_q[$];

  logic [13:0] outs;
  assign outs = {pll_resetb, dom_rst_n, ready, lock_lost, retry_count};

  function automatic logic [13:0] pk(input logic rb, input logic [2:0] d,
                                     input logic rdy, input logic lost,
                                     input logic [7:0] rc);
    return {rb, d, rdy, lost, rc};
  endfunction

  task automatic push(input string tag, input int c, input logic [13:0] v);
    exp_t e;
    e.tag = tag;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_drained(input string tag);
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s: observed %0d pending changes expected 0 (next %s @%0d)",
             tag, exp_q.size(), exp_q[0].tag, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input logic lk);
    @(negedge clk);
    rst_n      = 1'b0;
    pll_locked = lk;
    clear_lost = 1'b0;
    #1;
    check("reset_values", outs, pk(1'b0, 3'b000, 1'b0, 1'b0, 8'd0));
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every output change must match the next queued expectation
  logic [13:0] prev = '0;
  exp_t        cur_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (outs !== prev)) begin
        n_assert++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_change: observed %h at cyc %0d expected no change", outs, cyc);
        end
        if (exp_q.size() > 0) begin
          cur_e = exp_q.pop_front();
          n_assert++;
          assert (outs === cur_e.vec && cyc == cur_e.cyc) else begin
            n_fail++;
            $error("FAIL %s: observed %h at cyc %0d expected %h at cyc %0d",
                   cur_e.tag, outs, cyc, cur_e.vec, cur_e.cyc);
          end
        end
      end
      prev = outs;
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected end of test");
    $fatal(1, "bench timeout");
  end

  initial begin
    // S1: lock present from the start, full staggered release
    do_reset(1'b1);
    push("s1_pll_rst_done", 4,  pk(1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    push("s1_dom0",         14, pk(1'b1, 3'b001, 1'b0, 1'b0, 8'd0));
    push("s1_dom1",         18, pk(1'b1, 3'b011, 1'b0, 1'b0, 8'd0));
    push("s1_dom2_ready",   22, pk(1'b1, 3'b111, 1'b1, 1'b0, 8'd0));
    rst_n = 1'b1;
    wait_cyc(30);
    check_drained("s1_release_seq");
    check("s1_retry_zero", 14'(retry_count), 14'd0);

    // S2: no lock for 100 cycles, two watchdog retries
    do_reset(1'b0);
    push("s2_pll_rst_done", 4,  pk(1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    push("s2_timeout1",     36, pk(1'b0, 3'b000, 1'b0, 1'b0, 8'd1));
    push("s2_retry1_done",  40, pk(1'b1, 3'b000, 1'b0, 1'b0, 8'd1));
    push("s2_timeout2",     72, pk(1'b0, 3'b000, 1'b0, 1'b0, 8'd2));
    push("s2_retry2_done",  76, pk(1'b1, 3'b000, 1'b0, 1'b0, 8'd2));
    rst_n = 1'b1;
    wait_cyc(100);
    check_drained("s2_watchdog_seq");
    check("s2_retry_two", 14'(retry_count), 14'd2);
    check("s2_dom_held", 14'(dom_rst_n), 14'd0);

    // S3: one-cycle lock glitch at STABLE count 5 restarts qualification
    do_reset(1'b1);
    push("s3_pll_rst_done", 4,  pk(1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    push("s3_dom0",         21, pk(1'b1, 3'b001, 1'b0, 1'b0, 8'd0));
    push("s3_dom1",         25, pk(1'b1, 3'b011, 1'b0, 1'b0, 8'd0));
    push("s3_dom2_ready",   29, pk(1'b1, 3'b111, 1'b1, 1'b0, 8'd0));
    rst_n = 1'b1;
    wait_cyc(8);
    pll_locked = 1'b0;
    wait_cyc(9);
    pll_locked = 1'b1;
    wait_cyc(32);
    check_drained("s3_glitch_restart");

    // S4: lock drops in RUN, then returns for a full re-sequence
    push("s4_lock_loss",    38, pk(1'b1, 3'b000, 1'b0, 1'b1, 8'd0));
    push("s4_dom0",         52, pk(1'b1, 3'b001, 1'b0, 1'b1, 8'd0));
    push("s4_dom1",         56, pk(1'b1, 3'b011, 1'b0, 1'b1, 8'd0));
    push("s4_dom2_ready",   60, pk(1'b1, 3'b111, 1'b1, 1'b1, 8'd0));
    wait_cyc(35);
    pll_locked = 1'b0;
    wait_cyc(40);
    pll_locked = 1'b1;
    wait_cyc(64);
    check_drained("s4_loss_resequence");

    // S5: clear alone clears; clear coincident with a new loss is overridden
    push("s5_clear_alone",  66, pk(1'b1, 3'b111, 1'b1, 1'b0, 8'd0));
    push("s5_set_beats_clr",73, pk(1'b1, 3'b000, 1'b0, 1'b1, 8'd0));
    wait_cyc(65);
    clear_lost = 1'b1;
    wait_cyc(66);
    clear_lost = 1'b0;
    wait_cyc(70);
    pll_locked = 1'b0;
    wait_cyc(72);
    clear_lost = 1'b1;
    wait_cyc(73);
    clear_lost = 1'b0;
    wait_cyc(80);
    check_drained("s5_clear_seq");
    check("s5_lost_sticky", 14'(lock_lost), 14'd1);

    // S6: rst_n mid-RELEASE returns outputs at once and restarts
    do_reset(1'b1);
    push("s6_pll_rst_done", 4,  pk(1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    push("s6_dom0",         14, pk(1'b1, 3'b001, 1'b0, 1'b0, 8'd0));
    rst_n = 1'b1;
    wait_cyc(15);
    check("s6_dom_partial", 14'(dom_rst_n), 14'b001);
    check_drained("s6_pre_reset");
    do_reset(1'b1);
    push("s6_re_pll_rst",   4,  pk(1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    push("s6_re_dom0",      14, pk(1'b1, 3'b001, 1'b0, 1'b0, 8'd0));
    push("s6_re_dom1",      18, pk(1'b1, 3'b011, 1'b0, 1'b0, 8'd0));
    push("s6_re_dom2",      22, pk(1'b1, 3'b111, 1'b1, 1'b0, 8'd0));
    rst_n = 1'b1;
    wait_cyc(3);
    check("s6_resetb_low", 14'(pll_resetb), 14'd0);
    wait_cyc(30);
    check_drained("s6_restart_seq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
